mic1_bus_sequencer: RTL and testbench

//  Sequences one MIC-1 microinstruction's datapath phases over the shared B/C buses.

---
 rtl/mic1_pkg.sv | 48 ++++
 rtl/mic1_bus_sequencer_bsel.sv | 21 ++
 rtl/mic1_bus_sequencer.sv | 137 +++++++++++++
 tb/tb_mic1_bus_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 bus sequencer: FSM state encoding,
// B-bus source codes, C-bus destination bit positions and mem_op bit indices.
package mic1_pkg;

    localparam int DEF_NUM_B       = 9;
    localparam int DEF_NUM_C       = 9;
    localparam int DEF_MEM_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_MEM   = 2'd3
    } state_e;

    // B-bus source codes
    localparam logic [3:0] B_MDR  = 4'd0;
    localparam logic [3:0] B_PC   = 4'd1;
    localparam logic [3:0] B_MBR  = 4'd2;
    localparam logic [3:0] B_MBRU = 4'd3;
    localparam logic [3:0] B_SP   = 4'd4;
    localparam logic [3:0] B_LV   = 4'd5;
    localparam logic [3:0] B_CPP  = 4'd6;
    localparam logic [3:0] B_TOS  = 4'd7;
    localparam logic [3:0] B_OPC  = 4'd8;

    // C-bus destination mask bit positions
    localparam int C_H   = 0;
    localparam int C_OPC = 1;
    localparam int C_TOS = 2;
    localparam int C_CPP = 3;
    localparam int C_LV  = 4;
    localparam int C_SP  = 5;
    localparam int C_PC  = 6;
    localparam int C_MDR = 7;
    localparam int C_MAR = 8;

    // mem_op bit indices
    localparam int MEM_WR    = 0;
    localparam int MEM_RD    = 1;
    localparam int MEM_FETCH = 2;

    // Read and write share the MDR path, so asking for both is meaningless.
    function automatic logic mem_op_conflict(input logic [2:0] op);
        return op[MEM_WR] & op[MEM_RD];
    endfunction

endpackage

// File: rtl/mic1_bus_sequencer_bsel.sv
// B-bus source decoder: 4-bit code to one-hot outEnable plus invalid flag.
module mic1_bsel_decoder
    import mic1_pkg::*;
#(
    parameter int NUM_B = DEF_NUM_B
) (
    input  logic [3:0]       code,
    output logic [NUM_B-1:0] onehot,
    output logic             invalid
);

    // One-hot decode; codes beyond the source count leave the bus undriven.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_B; i++) begin
            if (code == 4'(i)) onehot[i] = 1'b1;
        end
        invalid = (onehot == '0);
    end

endmodule

// File: rtl/mic1_bus_sequencer.sv
// MIC-1 microinstruction bus sequencer: drives B/C bus enables and the
// memory read/write/fetch handshake for one microinstruction at a time.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | ready for fields; buses floating
//   DRIVE    | B-bus source enabled onto the ALU input
//   WRITE    | B-bus held, C-bus destinations enabled (capture at exit edge)
//   MEM      | memory strobes active until mem_ready or timeout
module mic1_bus_sequencer
    import mic1_pkg::*;
#(
    parameter int NUM_B       = DEF_NUM_B,
    parameter int NUM_C       = DEF_NUM_C,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             uinstr_valid,
    output logic             uinstr_ready,
    input  logic [3:0]       b_sel,
    input  logic [NUM_C-1:0] c_mask,
    input  logic [2:0]       mem_op,
    output logic [NUM_B-1:0] out_en,
    output logic [NUM_C-1:0] in_en,
    output logic             mem_write,
    output logic             mem_read,
    output logic             mem_fetch,
    input  logic             mem_ready,
    output logic             mdr_load,
    output logic             mbr_load,
    output logic             busy,
    output logic             bus_err,
    input  logic             err_clr
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [3:0]         b_sel_q, b_sel_d;
    logic [NUM_C-1:0]   c_mask_q, c_mask_d;
    logic [2:0]         mem_op_q, mem_op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_err_q, bus_err_d;
    logic               err_set;
    logic [NUM_B-1:0]   b_onehot;
    logic               b_invalid;
    logic               in_mem;

    mic1_bsel_decoder #(.NUM_B(NUM_B)) u_bsel (
        .code    (b_sel_q),
        .onehot  (b_onehot),
        .invalid (b_invalid)
    );

    // Next-state, field latch, timeout counter and sticky error computation.
    always_comb begin
        state_d  = state_q;
        b_sel_d  = b_sel_q;
        c_mask_d = c_mask_q;
        mem_op_d = mem_op_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (uinstr_valid) begin
                    b_sel_d  = b_sel;
                    c_mask_d = c_mask;
                    mem_op_d = mem_op;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (b_invalid) err_set = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (mem_op_conflict(mem_op_q)) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else if (mem_op_q != 3'b000) begin
                    cnt_d   = '0;
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new error wins over a clear arriving in the same cycle.
        if (err_set)      bus_err_d = 1'b1;
        else if (err_clr) bus_err_d = 1'b0;
        else              bus_err_d = bus_err_q;
    end

    // All sequencer state; reset forces IDLE so every enable drops at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            b_sel_q   <= '0;
            c_mask_q  <= '0;
            mem_op_q  <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_sel_q   <= b_sel_d;
            c_mask_q  <= c_mask_d;
            mem_op_q  <= mem_op_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign in_mem       = (state_q == ST_MEM);
    assign out_en       = (state_q == ST_DRIVE || state_q == ST_WRITE) ? b_onehot : '0;
    assign in_en        = (state_q == ST_WRITE) ? c_mask_q : '0;
    assign mem_write    = in_mem & mem_op_q[MEM_WR];
    assign mem_read     = in_mem & mem_op_q[MEM_RD];
    assign mem_fetch    = in_mem & mem_op_q[MEM_FETCH];
    assign mdr_load     = in_mem & mem_ready & mem_op_q[MEM_RD];
    assign mbr_load     = in_mem & mem_ready & mem_op_q[MEM_FETCH];
    assign uinstr_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mic1_bus_sequencer.sv
// Self-checking bench for mic1_bus_sequencer: directed cases plus random
// microinstructions compared cycle by cycle against a per-instruction model.
module tb_mic1_bus_sequencer;

    localparam int NB  = 9;
    localparam int NC  = 9;
    localparam int TMO = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          uinstr_valid = 1'b0;
    logic          uinstr_ready;
    logic [3:0]    b_sel = '0;
    logic [NC-1:0] c_mask = '0;
    logic [2:0]    mem_op = '0;
    logic [NB-1:0] out_en;
    logic [NC-1:0] in_en;
    logic          mem_write, mem_read, mem_fetch;
    logic          mem_ready = 1'b0;
    logic          mdr_load, mbr_load;
    logic          busy, bus_err;
    logic          err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    bit err_exp = 1'b0;

    always #5 clock = ~clock;

    mic1_bus_sequencer #(.NUM_B(NB), .NUM_C(NC), .MEM_TIMEOUT(TMO)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .uinstr_valid (uinstr_valid),
        .uinstr_ready (uinstr_ready),
        .b_sel        (b_sel),
        .c_mask       (c_mask),
        .mem_op       (mem_op),
        .out_en       (out_en),
        .in_en        (in_en),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_fetch    (mem_fetch),
        .mem_ready    (mem_ready),
        .mdr_load     (mdr_load),
        .mbr_load     (mbr_load),
        .busy         (busy),
        .bus_err      (bus_err),
        .err_clr      (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"}, {mem_fetch, mem_read, mem_write}, 0);
        chk({tag, "_loads"}, {mbr_load, mdr_load}, 0);
    endtask

    // Issue one microinstruction from IDLE and follow it back to IDLE.
    // delay: MEM cycle index (0-based) in which mem_ready is raised; >= TMO means never.
    task automatic run_instr(input logic [3:0] b, input logic [NC-1:0] c,
                             input logic [2:0] m, input int delay);
        logic [NB-1:0] oe_exp;
        bit conflict, mem_go;
        oe_exp   = (b < 4'(NB)) ? (NB'(1) << b) : '0;
        conflict = m[0] & m[1];
        mem_go   = (m != 3'b000) && !conflict;
        chk("idle_ready", uinstr_ready, 1);
        uinstr_valid = 1'b1;
        b_sel  = b;
        c_mask = c;
        mem_op = m;
        @(posedge clock);
        @(negedge clock);
        uinstr_valid = 1'b0;
        b_sel  = 4'($urandom);
        c_mask = NC'($urandom);
        mem_op = 3'($urandom);
        #1;
        chk("drive_out_en", out_en, oe_exp);
        chk("drive_in_en", in_en, 0);
        chk("drive_busy_ready", {busy, uinstr_ready}, 2'b10);
        chk_quiet("drive");
        @(negedge clock);
        #1;
        chk("write_out_en", out_en, oe_exp);
        chk("write_in_en", in_en, c);
        chk_quiet("write");
        if (b >= 4'(NB)) err_exp = 1'b1;
        if (conflict) err_exp = 1'b1;
        if (mem_go) begin
            for (int k = 0; k < TMO; k++) begin
                @(negedge clock);
                mem_ready = (k == delay);
                #1;
                chk("mem_strobes", {mem_fetch, mem_read, mem_write}, m);
                chk("mem_buses", {out_en, in_en}, 0);
                chk("mem_loads", {mbr_load, mdr_load}, (k == delay) ? {m[2], m[1]} : 2'b00);
                chk("mem_busy", busy, 1);
                if (k == delay) break;
            end
            if (delay >= TMO) err_exp = 1'b1;
        end
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        chk("end_ready_busy", {uinstr_ready, busy}, 2'b10);
        chk("end_buses", {out_en, in_en}, 0);
        chk_quiet("end");
        chk("end_bus_err", bus_err, err_exp);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clock);
        @(negedge clock);
        err_clr = 1'b0;
        err_exp = 1'b0;
        #1;
        chk("err_clr", bus_err, 0);
        chk("err_clr_ready", uinstr_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]    rb;
        logic [NC-1:0] rc;
        logic [2:0]    rm;
        int            rd;

        // Reset state
        #1;
        chk("rst_buses", {out_en, in_en}, 0);
        chk_quiet("rst");
        chk("rst_ready_busy", {uinstr_ready, busy}, 2'b10);
        chk("rst_bus_err", bus_err, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;

        // MBR -> H, no memory op
        run_instr(4'd2, 9'h001, 3'b000, 0);
        // PC -> MAR with fetch, ready in third MEM cycle
        run_instr(4'd1, 9'h100, 3'b100, 2);
        // read+write conflict: no memory phase, sticky error
        run_instr(4'd5, 9'h010, 3'b011, 0);
        run_instr(4'd0, 9'h002, 3'b000, 0);
        clear_err();
        // illegal B source, C mask still applied
        run_instr(4'hC, 9'h0FF, 3'b000, 0);
        clear_err();
        // read timeout after MEM_TIMEOUT cycles
        run_instr(4'd3, 9'h100, 3'b010, 99);
        clear_err();
        // ready on the last allowed cycle and on the first
        run_instr(4'd0, 9'h080, 3'b001, TMO - 1);
        run_instr(4'd8, 9'h180, 3'b110, 0);
        run_instr(4'd7, 9'h040, 3'b101, 4);

        // reset in the middle of a memory op
        run_instr(4'hF, 9'h000, 3'b000, 0);
        uinstr_valid = 1'b1;
        b_sel  = 4'd1;
        c_mask = 9'h100;
        mem_op = 3'b110;
        @(posedge clock);
        @(negedge clock);
        uinstr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("pre_rst_mem", {mem_fetch, mem_read, mem_write}, 3'b110);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_buses", {out_en, in_en}, 0);
        chk_quiet("async_rst");
        chk("async_rst_ready_busy", {uinstr_ready, busy}, 2'b10);
        chk("async_rst_bus_err", bus_err, 0);
        @(negedge clock);
        reset_n = 1'b1;
        err_exp = 1'b0;
        #1;
        chk("post_rst_ready", uinstr_ready, 1);
        chk("post_rst_bus_err", bus_err, 0);

        // random microinstructions
        repeat (40) begin
            if ($urandom_range(0, 9) == 0) rb = 4'($urandom_range(9, 15));
            else                           rb = 4'($urandom_range(0, 8));
            rc = NC'($urandom);
            rm = 3'($urandom_range(0, 7));
            if (rb >= 4'(NB)) rm = 3'b000;
            rd = $urandom_range(0, 19);
            run_instr(rb, rc, rm, rd);
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
